// File: rtl/iterative_narrow_multiplier_pkg.sv
// Shared definitions for the iterative narrow multiplier: FSM state
// encodings and the number of half-product steps per operation.
package narrow_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_STEPS = 4;

endpackage

// File: rtl/iterative_narrow_multiplier_array_mult.sv
// Generic combinational unsigned array multiplier, m x n bits -> m+n bits.
// Each row is the multiplicand gated by one multiplier bit, shifted into
// place and summed.
module ArrayMultiplier_generic #(
   parameter int m = 8,
   parameter int n = 8
) (
   input  logic [m-1:0]   a,
   input  logic [n-1:0]   b,
   output logic [m+n-1:0] p
);

   // Sum of shifted partial-product rows.
   always_comb begin
      p = '0;
      for (int i = 0; i < n; i++) begin
         if (b[i]) begin
            p = p + ({{n{1'b0}}, a} << i);
         end
      end
   end

endmodule

// File: rtl/iterative_narrow_multiplier.sv
// Iterative multiplier: a single (WIDTH/2)x(WIDTH/2) array multiplier is
// reused over four steps (LL, LH, HL, HH) to build the 2*WIDTH-bit product.
// Optional feature macro: SIGNED_MODE_EN adds the in_signed port; signed
// operands are converted to magnitudes on acceptance and the result is
// negated on the final accumulation edge.
//
// Handshake: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; a product transfers on a rising edge where
// out_valid and out_ready are both high. product stays stable while
// out_valid is high and out_ready is low.
module iterative_narrow_multiplier
   import narrow_mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
`ifdef SIGNED_MODE_EN
   input  logic               in_signed,
`endif
   output logic [1:0]         state_dbg
);

   localparam int HALF = WIDTH / 2;

   state_t               state;
   logic [1:0]           step;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc;
   logic [HALF-1:0]      mul_a;
   logic [HALF-1:0]      mul_b;
   logic [WIDTH-1:0]     half_prod;
   logic [2*WIDTH-1:0]   term;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   final_val;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;

`ifdef SIGNED_MODE_EN
   logic                 neg_q;
   logic                 neg_in;

   // Convert signed operands to magnitudes and work out the result sign.
   always_comb begin
      a_in   = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_in   = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
      neg_in = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
   end

   assign final_val = neg_q ? (~acc_next + 1'b1) : acc_next;
`else
   assign a_in      = a;
   assign b_in      = b;
   assign final_val = acc_next;
`endif

   // The one shared array multiplier.
   ArrayMultiplier_generic #(
      .m (HALF),
      .n (HALF)
   ) u_array_mult (
      .a (mul_a),
      .b (mul_b),
      .p (half_prod)
   );

   // Step-indexed operand half-select and alignment of the half-product.
   always_comb begin
      mul_a = a_q[HALF-1:0];
      mul_b = b_q[HALF-1:0];
      term  = {{WIDTH{1'b0}}, half_prod};
      case (step)
         2'd0: begin
            mul_a = a_q[HALF-1:0];
            mul_b = b_q[HALF-1:0];
            term  = {{WIDTH{1'b0}}, half_prod};
         end
         2'd1: begin
            mul_a = a_q[HALF-1:0];
            mul_b = b_q[WIDTH-1:HALF];
            term  = {{WIDTH{1'b0}}, half_prod} << HALF;
         end
         2'd2: begin
            mul_a = a_q[WIDTH-1:HALF];
            mul_b = b_q[HALF-1:0];
            term  = {{WIDTH{1'b0}}, half_prod} << HALF;
         end
         default: begin
            mul_a = a_q[WIDTH-1:HALF];
            mul_b = b_q[WIDTH-1:HALF];
            term  = {{WIDTH{1'b0}}, half_prod} << WIDTH;
         end
      endcase
      acc_next = acc + term;
   end

   // Control FSM with registered handshake outputs and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         acc       <= '0;
         step      <= '0;
         a_q       <= '0;
         b_q       <= '0;
`ifdef SIGNED_MODE_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a_in;
                  b_q      <= b_in;
`ifdef SIGNED_MODE_EN
                  neg_q    <= neg_in;
`endif
                  acc      <= '0;
                  step     <= '0;
                  in_ready <= 1'b0;
                  state    <= MUL;
               end
            end
            MUL: begin
               acc  <= acc_next;
               step <= step + 2'd1;
               if (step == 2'(NUM_STEPS - 1)) begin
                  product   <= final_val;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_iterative_narrow_multiplier.sv
// Self-checking bench for iterative_narrow_multiplier (WIDTH = 16).
// Define SIGNED_MODE_EN on both RTL and bench to exercise signed mode.
module tb_iterative_narrow_multiplier;
   import narrow_mult_pkg::*;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;
   logic [1:0]     state_dbg;
`ifdef SIGNED_MODE_EN
   logic           in_signed;
`endif

   int             tests = 0;
   int             fails = 0;
   logic [2*W-1:0] exp_q[$];
   bit             rand_ready = 1'b0;

   iterative_narrow_multiplier #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
`ifdef SIGNED_MODE_EN
      .in_signed (in_signed),
`endif
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: pop one expected product per output handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL extra_result: observed product 0x%0h expected no result", product);
            end
         end else begin
            check("product", {32'd0, product}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   // Random consumer backpressure during the random phase.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] expv, input bit sgn);
      wait_idle();
      a        = av;
      b        = bv;
`ifdef SIGNED_MODE_EN
      in_signed = sgn;
`else
      if (sgn) $display("signed request ignored in unsigned build");
`endif
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(expv);
      #1 in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic latency(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end while (out_valid !== 1'b1 && cyc < 20);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid", {63'd0, out_valid}, 64'd1);
   endtask

   initial begin
      int          lat;
      int          n;
      bit          seen;
      logic [W-1:0] x;
      logic [W-1:0] y;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
`ifdef SIGNED_MODE_EN
      in_signed = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_product", {32'd0, product}, 64'd0);
      check("reset_state", {62'd0, state_dbg}, {62'd0, IDLE});

      // Directed product and latency
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(16'h1234, 16'h5678, 32'h0626_0060, 1'b0);
      latency(lat);
      check("latency_first", 64'(lat), 64'd4);
      repeat (3) @(negedge clk);
      check("idle_holds_product", {32'd0, product}, 64'h0626_0060);
      check("idle_in_ready", {63'd0, in_ready}, 64'd1);

      // Backpressure hold with ignored in_valid
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
      wait_valid();
      in_valid = 1'b1;
      a = 16'h0003;
      b = 16'h0003;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_product", {32'd0, product}, 64'hFFFE_0001);
         check("hold_out_valid", {63'd0, out_valid}, 64'd1);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;

      // in_valid held high: second pair only taken after DONE->IDLE
      wait_idle();
      a = 16'd3;
      b = 16'd5;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(32'd15);
      #1 a = 16'd7;
      b = 16'd9;
      exp_q.push_back(32'd63);
      repeat (6) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("b2b_accept_in_ready", {63'd0, in_ready}, 64'd0);
      check("b2b_accept_state", {62'd0, state_dbg}, {62'd0, MUL});

      // Reset during MUL step 2 abandons the operation
      wait_idle();
      a = 16'h1111;
      b = 16'h2222;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_reset_product", {32'd0, product}, 64'd0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check("mid_reset_no_result", {63'd0, seen}, 64'd0);

      // Zero operands still take all four steps
      send(16'h0000, 16'h0000, 32'h0000_0000, 1'b0);
      latency(lat);
      check("latency_zero", 64'(lat), 64'd4);

`ifdef SIGNED_MODE_EN
      send(16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 1'b1);
      latency(lat);
      check("latency_signed", 64'(lat), 64'd4);
      send(16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
      send(16'hFFFF, 16'h0002, 32'h0001_FFFE, 1'b0);
      send(16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
`endif

      // Random unsigned pairs with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         x = W'($urandom_range(0, 16'hFFFF));
         y = W'($urandom_range(0, 16'hFFFF));
         send(x, y, {16'd0, x} * {16'd0, y}, 1'b0);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
